// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: two-port round-robin sequencer in front of the data memory.
// One access at a time: IDLE (arbitrate) -> ACCESS (DM strobe) -> RESP (pulse).
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req0_* / rsp0_*          port 0 (load/store unit): valid/ready request,
//                            one-cycle response pulse with rdata and err
//   req1_* / rsp1_*          port 1 (DMA/debug loader), same shape as port 0
//   MemAddr, MemWriteData    address/store data to DM, held outside ACCESS
//   MemWrite, MemRead        DM strobes, only ever high in ACCESS
//   MemReadData              combinational read data from DM
//
// Build option: define DM_ARB_ALIGN_CHECK_EN to reject addresses with
// addr[1:0] != 0 the same way as out-of-bounds accesses.
module dm_port_arbiter #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);

    // Highest legal word start; comparing against it avoids the wrap that
    // addr+3 would suffer near 2^32.
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic              last_grant;
    logic              lat_port;
    logic              lat_write;
    logic              lat_err;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              any_valid;
    logic              pick;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;
    logic              hs;
    logic              rsp_fire0;
    logic              rsp_fire1;

    // Arbiter: on a tie the port that did not win last time is picked.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            pick = ~last_grant;
        end else begin
            pick = req1_valid;
        end
        sel_write = pick ? req1_write : req0_write;
        sel_addr  = pick ? req1_addr  : req0_addr;
        sel_wdata = pick ? req1_wdata : req0_wdata;
    end

    always_comb begin
        sel_err = (sel_addr > LAST_OK);
`ifdef DM_ARB_ALIGN_CHECK_EN
        if (sel_addr[1:0] != 2'b00) begin
            sel_err = 1'b1;
        end
`else
        // Misaligned words are legal: DM is byte addressed.
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        hs         = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        rsp_fire0  = 1'b0;
        rsp_fire1  = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid && !rst) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                    hs         = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // rst gates the store so a reset here never half-commits.
                MemWrite   = lat_write & ~lat_err & ~rst;
                MemRead    = ~lat_write & ~lat_err;
                state_next = RESP;
            end
            RESP: begin
                rsp_fire0  = ~rst & ~lat_port;
                rsp_fire1  = ~rst & lat_port;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_write  <= 1'b0;
            lat_err    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (hs) begin
                last_grant <= pick;
                lat_port   <= pick;
                lat_write  <= sel_write;
                lat_err    <= sel_err;
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
            end
            if (state == ACCESS) begin
                if (!lat_write && !lat_err) begin
                    rdata_q <= MemReadData;
                end else begin
                    rdata_q <= '0;
                end
            end
        end
    end

    assign MemAddr      = addr_q;
    assign MemWriteData = wdata_q;

    assign rsp0_valid = rsp_fire0;
    assign rsp1_valid = rsp_fire1;
    assign rsp0_rdata = rsp_fire0 ? rdata_q : '0;
    assign rsp1_rdata = rsp_fire1 ? rdata_q : '0;
    assign rsp0_err   = rsp_fire0 & lat_err;
    assign rsp1_err   = rsp_fire1 & lat_err;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed bench for dm_port_arbiter with a byte-wide
// 128-byte DM model (combinational read, store committed on negedge).
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_write;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_write;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [31:0] MemAddr, MemWriteData, MemReadData;
    logic        MemWrite, MemRead;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] dm [0:127];
    bit         dm_init;

    dm_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_write   (req0_write),
        .req0_addr    (req0_addr),
        .req0_wdata   (req0_wdata),
        .rsp0_valid   (rsp0_valid),
        .rsp0_rdata   (rsp0_rdata),
        .rsp0_err     (rsp0_err),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_write   (req1_write),
        .req1_addr    (req1_addr),
        .req1_wdata   (req1_wdata),
        .rsp1_valid   (rsp1_valid),
        .rsp1_rdata   (rsp1_rdata),
        .rsp1_err     (rsp1_err),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [31:0] pw(input int a);
        return {pat(a), pat(a + 1), pat(a + 2), pat(a + 3)};
    endfunction

    always_comb begin
        MemReadData = '0;
        if (MemAddr <= 32'd124) begin
            MemReadData = {dm[MemAddr[6:0]], dm[MemAddr[6:0] + 7'd1],
                           dm[MemAddr[6:0] + 7'd2], dm[MemAddr[6:0] + 7'd3]};
        end
    end

    always @(negedge clk) begin
        if (!dm_init) begin
            for (int i = 0; i < 128; i++) dm[i] <= pat(i);
            dm_init <= 1'b1;
        end else if (MemWrite && MemAddr <= 32'd124) begin
            dm[MemAddr[6:0]]         <= MemWriteData[31:24];
            dm[MemAddr[6:0] + 7'd1]  <= MemWriteData[23:16];
            dm[MemAddr[6:0] + 7'd2]  <= MemWriteData[15:8];
            dm[MemAddr[6:0] + 7'd3]  <= MemWriteData[7:0];
        end
    end

    // Enters at posedge+1 in IDLE, leaves at posedge+1 of the ACCESS cycle.
    task automatic do_req(input bit p, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        int n = 0;
        if (p) begin
            req1_write = w; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
        end else begin
            req0_write = w; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
        end
        while (!got && n < 10) begin
            @(negedge clk);
            got = p ? req1_ready : req0_ready;
            n++;
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: port %0d ready=0 after %0d cycles, required 1", p, n);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
             MemRead, MemWrite, rsp0_rdata, rsp1_rdata, MemAddr, MemWriteData} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got nonzero output (ready=%b%b memaddr=%h), required all 0",
                     req0_ready, req1_ready, MemAddr);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alternation();
        int ng = 0, nr = 0, c0 = 0, c1 = 0, cyc = 0;
        logic g;
        logic pp = 1'b0;
        logic [31:0] pdata = '0;
        req0_write = 0; req0_addr = 32'h00;
        req1_write = 0; req1_addr = 32'h40;
        req0_valid = 1; req1_valid = 1;
        while (nr < 8 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (rsp0_valid || rsp1_valid) begin
                vectors++;
                if ({rsp0_valid, rsp1_valid, rsp0_rdata | rsp1_rdata} !== {~pp, pp, pdata}) begin
                    miscompares++;
                    $display("FAIL alt_rsp%0d: got v=%b%b data=%h, required v=%b%b data=%h",
                             nr, rsp0_valid, rsp1_valid, rsp0_rdata | rsp1_rdata, ~pp, pp, pdata);
                end
                nr++;
            end else if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                g = req1_valid && req1_ready;
                vectors++;
                if (g !== ng[0]) begin
                    miscompares++;
                    $display("FAIL alt_grant%0d: got port %0d, required port %0d", ng, g, ng[0]);
                end
                ng++;
                pp = g;
                pdata = pw(int'(g ? req1_addr : req0_addr));
                @(posedge clk); #1;
                if (g) begin
                    c1++; req1_addr += 4;
                    if (c1 == 4) req1_valid = 0;
                end else begin
                    c0++; req0_addr += 4;
                    if (c0 == 4) req0_valid = 0;
                end
            end
        end
        if (nr < 8) begin
            vectors++; miscompares++;
            $display("FAIL alt_timeout: got %0d responses, required 8", nr);
        end
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        do_req(0, 1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        vectors++;
        if ({MemWrite, MemRead, MemAddr, MemWriteData} !== {2'b10, 32'h10, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL store_strobe: got w=%b r=%b a=%h d=%h, required w=1 r=0 a=10 d=deadbeef",
                     MemWrite, MemRead, MemAddr, MemWriteData);
        end
        @(posedge clk); #1;
        vectors++;
        if ({MemWrite, rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid} !== {3'b010, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL store_rsp: got w=%b v=%b e=%b d=%h v1=%b, required w=0 v=1 e=0 d=0 v1=0",
                     MemWrite, rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid);
        end
        @(posedge clk); #1;
        do_req(0, 0, 32'h10, 32'h0);
        @(negedge clk);
        vectors++;
        if ({MemWrite, MemRead} !== 2'b01) begin
            miscompares++;
            $display("FAIL load_strobe: got w=%b r=%b, required w=0 r=1", MemWrite, MemRead);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL load_rsp: got v=%b e=%b d=%h, required v=1 e=0 d=deadbeef",
                     rsp0_valid, rsp0_err, rsp0_rdata);
        end
        @(posedge clk); #1;
        vectors++;
        if (rsp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_pulse_width: got rsp0_valid=%b, required 0", rsp0_valid);
        end
    endtask

    task automatic test_oob();
        do_req(1, 0, 32'h7D, 32'h0);
        @(negedge clk);
        vectors++;
        if ({MemWrite, MemRead} !== 2'b00) begin
            miscompares++;
            $display("FAIL oob_strobe: got w=%b r=%b, required 00", MemWrite, MemRead);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid} !== {2'b11, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL oob_rsp: got v=%b e=%b d=%h v0=%b, required v=1 e=1 d=0 v0=0",
                     rsp1_valid, rsp1_err, rsp1_rdata, rsp0_valid);
        end
        @(posedge clk); #1;
        do_req(0, 1, 32'hFFFF_FFFE, 32'hA5A5A5A5);
        @(negedge clk);
        vectors++;
        if (MemWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_strobe: got MemWrite=%b, required 0", MemWrite);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp0_err} !== 2'b11) begin
            miscompares++;
            $display("FAIL wrap_rsp: got v=%b e=%b, required v=1 e=1", rsp0_valid, rsp0_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_last_word();
        do_req(0, 1, 32'h7C, 32'h11223344);
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp0_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL last_store_rsp: got v=%b e=%b, required v=1 e=0", rsp0_valid, rsp0_err);
        end
        @(posedge clk); #1;
        do_req(0, 0, 32'h7C, 32'h0);
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b10, 32'h11223344}) begin
            miscompares++;
            $display("FAIL last_load_rsp: got v=%b e=%b d=%h, required v=1 e=0 d=11223344",
                     rsp0_valid, rsp0_err, rsp0_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_req(0, 1, 32'h20, 32'hCAFEF00D);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (MemWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_access_write: got MemWrite=%b, required 0", MemWrite);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_access_rsp: got v=%b%b, required 00", rsp0_valid, rsp1_valid);
        end
        @(posedge clk); #1;
        do_req(0, 0, 32'h20, 32'h0);
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp0_rdata} !== {1'b1, pw(32'h20)}) begin
            miscompares++;
            $display("FAIL rst_reload: got v=%b d=%h, required v=1 d=%h",
                     rsp0_valid, rsp0_rdata, pw(32'h20));
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (rsp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resp_drop: got rsp0_valid=%b, required 0", rsp0_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_misaligned();
        logic        exp_err;
        logic [31:0] exp_mem;
`ifdef DM_ARB_ALIGN_CHECK_EN
        exp_err = 1'b1;
        exp_mem = pw(6);
`else
        exp_err = 1'b0;
        exp_mem = 32'h12345678;
`endif
        do_req(0, 1, 32'h06, 32'h12345678);
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {1'b1, exp_err, 32'h0}) begin
            miscompares++;
            $display("FAIL misalign_rsp: got v=%b e=%b d=%h, required v=1 e=%b d=0",
                     rsp0_valid, rsp0_err, rsp0_rdata, exp_err);
        end
        vectors++;
        if ({dm[6], dm[7], dm[8], dm[9]} !== exp_mem) begin
            miscompares++;
            $display("FAIL misalign_mem: got %h, required %h",
                     {dm[6], dm[7], dm[8], dm[9]}, exp_mem);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alternation();
        test_store_load();
        test_oob();
        test_last_word();
        test_reset_mid();
        test_misaligned();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 128-byte data memory (DM).
- Shares DM's single port between port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
- Arbitrates round-robin and runs one access at a time through a small FSM.
- Bounds-checks each access and returns registered read data with an error flag.

Parameters:
- MEM_BYTES, 128, DM size in bytes; an access is legal only if addr+3 < MEM_BYTES.
- ADDR_W, 32, requester and DM address width.
- DATA_W, 32, data width; fixed at 4 bytes per access.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 request present.
- req0_ready  output  1  port 0 request accepted this cycle when valid&ready.
- req0_write  input  1  1 = store, 0 = load.
- req0_addr  input  ADDR_W  byte address.
- req0_wdata  input  DATA_W  store data (big-endian: [31:24] goes to addr).
- rsp0_valid  output  1  one-cycle response pulse.
- rsp0_rdata  output  DATA_W  load data; 0 for stores and errors.
- rsp0_err  output  1  access rejected; valid with rsp0_valid.
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- MemAddr  output  ADDR_W  to DM.
- MemWriteData  output  DATA_W  to DM.
- MemWrite  output  1  to DM; DM commits on the negedge inside the cycle this is high.
- MemRead  output  1  to DM.
- MemReadData  input  DATA_W  from DM, combinational.

Behaviour:
- Reset (sync, active-high): state=IDLE; last_grant=1 (port 0 wins the first tie).
  - All outputs 0: req*_ready, rsp*_valid, rsp*_rdata, rsp*_err, MemRead, MemWrite, MemAddr, MemWriteData.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - reqN_ready = 1 only for the port the arbiter would pick. The other port's ready is 0.
  - Arbitration when both are valid: grant the port != last_grant.
  - When only one is valid: grant that port.
  - On handshake: latch port id, write, addr, wdata; compute err (out of bounds); update last_grant; go to ACCESS.
  - No valid request: stay in IDLE.
- ACCESS (exactly one cycle):
  - MemAddr and MemWriteData are driven from the latches.
  - MemWrite = latched write & !err & !rst.
  - MemRead = !latched write & !err.
  - At the closing posedge: capture MemReadData into rdata (load without error; otherwise 0); go to RESP.
- RESP (one cycle):
  - rspN_valid=1 for the granted port only, with rdata and err. No backpressure.
  - Next state is IDLE. Any request already valid is arbitrated in the following IDLE cycle.
- Latency and throughput:
  - Handshake at edge N; DM access in cycle N..N+1; response visible in cycle N+1..N+2.
  - Throughput: one access per 3 cycles.
- Outside ACCESS: MemRead=MemWrite=0; MemAddr/MemWriteData hold their last values.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1. Maximum wait is one foreign transaction.
- Error (addr > MEM_BYTES-4, including address wrap near 2^32):
  - No DM strobe.
  - rsp_err=1, rdata=0.
  - last_grant still updates.
- Reset mid-operation:
  - rst in ACCESS suppresses MemWrite that cycle, so no partial store.
  - rst in RESP drops the pending response pulse.
- A requester may change its request fields while ready=0. Fields are sampled only on the handshake edge.

Optional Feature:
- Macro: DM_ARB_ALIGN_CHECK_EN.
- Defined: addr[1:0] != 0 is treated as an error, with the same handling as out-of-bounds: no DM strobe, err=1, rdata=0.
- Undefined: misaligned word addresses are legal. DM is byte-addressed, so an access to addr 0x05 reads/writes bytes 5..8 big-endian.

Test Plan:
- Port 0 store addr 0x10 data 0xDEADBEEF, then port 0 load 0x10 -> MemWrite is high for exactly one cycle; load response rsp0_rdata=0xDEADBEEF, err=0, 2 cycles after its handshake.
- Both ports valid from reset, each issuing 4 loads -> grants go 0,1,0,1,0,1,0,1; each rsp pulses only on the owning port.
- Port 1 load addr 0x7D (MEM_BYTES=128) -> rsp1_err=1, rdata=0; MemRead and MemWrite stay 0.
- Port 0 store 0x7C data 0x11223344 -> err=0; a subsequent load of 0x7C returns 0x11223344 (last legal word).
- rst asserted during the ACCESS cycle of a store to 0x20 -> MemWrite stays 0; a reload of 0x20 after reset returns the old contents; no rsp pulse.
- Store 0x12345678 to addr 0x06 -> with DM_ARB_ALIGN_CHECK_EN: err=1 and DM unchanged; without it: err=0 and DM bytes 6..9 = 12,34,56,78.
